// File: rtl/tri_wb_loader.sv
// Wishbone write initiator: takes one 4-word triangle descriptor and writes it to the selected interp_tri tile.
// Optional ack timeout abort enabled by defining TRI_WB_TIMEOUT_EN.
module tri_wb_loader #(
    parameter int unsigned NTRI    = 64,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [IDX_W-1:0] cmd_idx_i,
    input  logic [127:0]     cmd_data_i,
    output logic             wbm_cyc_o,
    output logic [NTRI-1:0]  wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [1:0]       wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [NTRI-1:0]  wbm_ack_i,
    output logic             busy_o,
    output logic             err_o,
    input  logic             err_clr_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DROP
    } state_t;

    state_t          state_q;
    logic [3:0][31:0] words_q;
    logic [1:0]      word_q;

    logic accept_c;
    logic range_bad_c;
    logic ack_hit_c;
    logic timeout_c;
    logic err_set_c;

    // The registered strobe is one-hot on the latched index, so masking acks with it qualifies them.
    always_comb begin
        accept_c    = 1'b0;
        range_bad_c = 1'b0;
        ack_hit_c   = 1'b0;
        err_set_c   = 1'b0;
        accept_c    = cmd_valid_i && cmd_ready_o && (state_q == ST_IDLE);
        range_bad_c = 32'(cmd_idx_i) >= NTRI;
        ack_hit_c   = (state_q == ST_XFER) && (|(wbm_ack_i & wbm_stb_o));
        err_set_c   = (accept_c && range_bad_c) || timeout_c;
    end

`ifdef TRI_WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt_q;

    // Per-word wait counter; restarts on each new word and on every qualified ack.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q != ST_XFER || ack_hit_c) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == ST_XFER) && !ack_hit_c && (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TIMEOUT);
    assign timeout_c          = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            words_q     <= '0;
            word_q      <= '0;
            cmd_ready_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= '0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        words_q     <= cmd_data_i;
                        word_q      <= '0;
                        cmd_ready_o <= 1'b0;
                        if (range_bad_c) begin
                            state_q <= ST_DROP;
                        end else begin
                            state_q   <= ST_XFER;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= NTRI'(1) << cmd_idx_i;
                            wbm_we_o  <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            wbm_adr_o <= 2'd0;
                            wbm_dat_o <= cmd_data_i[31:0];
                        end
                    end
                end
                ST_XFER: begin
                    if (ack_hit_c && word_q != 2'd3) begin
                        word_q    <= word_q + 2'd1;
                        wbm_adr_o <= word_q + 2'd1;
                        wbm_dat_o <= words_q[word_q + 2'd1];
                    end else if (ack_hit_c || timeout_c) begin
                        // Last word acked or wait expired: release the bus in one edge.
                        state_q     <= ST_IDLE;
                        cmd_ready_o <= 1'b1;
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= '0;
                        wbm_we_o    <= 1'b0;
                        wbm_sel_o   <= '0;
                        wbm_adr_o   <= '0;
                        wbm_dat_o   <= '0;
                    end
                end
                ST_DROP: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_o <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_o <= 1'b1;
                end
            endcase

            // A new error in the same cycle beats a clear.
            if (err_set_c) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

    assign busy_o = wbm_cyc_o;

endmodule

// File: tb/tb_tri_wb_loader.sv
// Directed self-checking bench for tri_wb_loader (NTRI = 48, IDX_W = 6, TIMEOUT = 15).
module tb_tri_wb_loader;

    localparam int unsigned NTRI    = 48;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_idx;
    logic [127:0]     cmd_data;
    logic             cyc;
    logic [NTRI-1:0]  stb;
    logic             we;
    logic [3:0]       sel;
    logic [1:0]       adr;
    logic [31:0]      dat;
    logic [NTRI-1:0]  ack;
    logic             busy;
    logic             err;
    logic             err_clr;

    // Slave model: mode 0 silent, 1 acks one cycle after stb, 2 acks in the same cycle.
    int              mode     = 0;
    logic            block_w2 = 1'b0;
    logic [NTRI-1:0] stray    = '0;
    logic [NTRI-1:0] ack_reg;

    int errors = 0;
    int checks = 0;

    int          log_n = 0;
    logic [1:0]  log_adr[64];
    logic [31:0] log_dat[64];
    logic [NTRI-1:0] log_stb[64];
    logic [3:0]  log_sel[64];
    logic        log_we[64];

    localparam logic [127:0] D1 = {32'hD, 32'hC, 32'hB, 32'hA};
    localparam logic [127:0] D2 = {32'h1004, 32'h1003, 32'h1002, 32'h1001};
    localparam logic [127:0] D3 = {32'h2004, 32'h2003, 32'h2002, 32'h2001};

    tri_wb_loader #(.NTRI(NTRI), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_idx_i  (cmd_idx),
        .cmd_data_i (cmd_data),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_sel_o  (sel),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat),
        .wbm_ack_i  (ack),
        .busy_o     (busy),
        .err_o      (err),
        .err_clr_i  (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ack_reg <= '0;
        else ack_reg <= (mode == 1 && cyc && ack_reg == '0 && !(block_w2 && adr == 2'd2)) ? stb : '0;
    end

    assign ack = ack_reg | ((mode == 2 && cyc) ? stb : '0) | stray;

    // Record every completed write beat.
    always @(posedge clk) begin
        if (cyc && (|(ack & stb)) && log_n < 64) begin
            log_adr[log_n] <= adr;
            log_dat[log_n] <= dat;
            log_stb[log_n] <= stb;
            log_sel[log_n] <= sel;
            log_we[log_n]  <= we;
            log_n          <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [IDX_W-1:0] idx, input logic [127:0] data);
        chk("ready_before_send", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_idx   = idx;
        cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && cyc; i++) @(negedge clk);
        chk("wait_idle", 64'(cyc), 64'd0);
    endtask

    task automatic chk_log(input string tag, input int base, input logic [127:0] data);
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_adr"}, 64'(log_adr[base + k]), 64'(k));
            chk({tag, "_dat"}, 64'(log_dat[base + k]), 64'(data[32*k +: 32]));
            chk({tag, "_stb"}, 64'(log_stb[base + k]), 64'h20);
            chk({tag, "_sel_we"}, {59'd0, log_we[base + k], log_sel[base + k]}, 64'h1F);
        end
    endtask

    initial begin
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_idx   = '0;
        cmd_data  = '0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 64'(cyc), 64'd0);
        chk("rst_stb", 64'(stb), 64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cyc", 64'(cyc), 64'd0);
        chk("idle_busy_dat", {31'd0, busy, dat}, 64'd0);

        // Ack seen while idle is ignored.
        stray = 48'h20;
        @(negedge clk);
        stray = '0;
        chk("idle_ack_cyc_err", {62'd0, cyc, err}, 64'd0);

        // Basic transfer, slave acking one cycle after stb.
        mode = 1;
        base = log_n;
        send(6'd5, D1);
        chk("x1_first", {cyc, busy, we, sel, adr, dat}, {1'b1, 1'b1, 1'b1, 4'hF, 2'd0, 32'hA});
        chk("x1_stb", 64'(stb), 64'h20);
        chk("x1_ready_low", 64'(cmd_ready), 64'd0);
        repeat (7) @(negedge clk);
        chk("x1_lat_n7", {63'(log_n - base), cyc}, {63'd3, 1'b1});
        @(negedge clk);
        chk("x1_lat_n8", {63'(log_n - base), cyc}, {63'd4, 1'b0});
        chk("x1_ready_back", 64'(cmd_ready), 64'd1);
        chk("x1_released", {we, sel, dat}, 64'd0);
        chk_log("x1", base, D1);

        // Same-cycle slave: acks on N+1..N+4.
        mode = 2;
        base = log_n;
        send(6'd5, D2);
        repeat (3) @(negedge clk);
        chk("x2_lat_n3", {63'(log_n - base), cyc}, {63'd3, 1'b1});
        @(negedge clk);
        chk("x2_lat_n4", {63'(log_n - base), cyc}, {63'd4, 1'b0});
        chk_log("x2", base, D2);

        // Stray ack on bit 7 must not advance the word.
        mode  = 0;
        base  = log_n;
        send(6'd5, D1);
        stray = 48'h80;
        repeat (3) @(negedge clk);
        chk("stray_hold", {61'(log_n - base), cyc, adr}, {61'd0, 1'b1, 2'd0});
        stray = '0;
        mode  = 1;
        wait_idle(20);
        chk("stray_done", 64'(log_n - base), 64'd4);

        // Back-to-back: second descriptor held valid across the transfer.
        @(negedge clk);
        base      = log_n;
        cmd_valid = 1'b1;
        cmd_idx   = 6'd5;
        cmd_data  = D1;
        @(posedge clk);
        @(negedge clk);
        cmd_data = D3;
        repeat (8) @(negedge clk);
        chk("b2b_gap", {62'd0, cyc, cmd_ready}, {62'd0, 1'b0, 1'b1});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("b2b_second", {cyc, cmd_ready, adr, dat}, {1'b1, 1'b0, 2'd0, 32'h2001});
        wait_idle(20);
        chk("b2b_count", 64'(log_n - base), 64'd8);
        chk_log("b2b", base + 4, D3);

        // Out-of-range index: dropped, error flagged, ready back after one cycle.
        @(negedge clk);
        send(6'd50, D1);
        chk("oor_n0", {61'd0, cyc, cmd_ready, err}, {61'd0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        chk("oor_n1", {62'd0, cyc, cmd_ready}, {62'd0, 1'b0, 1'b1});
        // A new error in the same cycle as a clear keeps err set.
        err_clr = 1'b1;
        send(6'd50, D1);
        err_clr = 1'b0;
        chk("oor_set_wins", 64'(err), 64'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("oor_clr", 64'(err), 64'd0);

        // Slave never acks word 2.
        mode     = 1;
        block_w2 = 1'b1;
        base     = log_n;
        send(6'd5, D1);
`ifdef TRI_WB_TIMEOUT_EN
        repeat (18) @(negedge clk);
        chk("tmo_before", {61'd0, cyc, adr}, {61'd0, 1'b1, 2'd2});
        chk("tmo_before_err", 64'(err), 64'd0);
        @(negedge clk);
        chk("tmo_abort", {62'd0, cyc, err}, {62'd0, 1'b0, 1'b1});
        chk("tmo_ready", {63'(log_n - base), cmd_ready}, {63'd2, 1'b1});
        block_w2 = 1'b0;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_clr", 64'(err), 64'd0);
`else
        repeat (30) @(negedge clk);
        chk("wait_forever", {60'd0, cyc, err, adr}, {60'd0, 1'b1, 1'b0, 2'd2});
        block_w2 = 1'b0;
        wait_idle(20);
        chk("wait_done", {63'(log_n - base), err}, {63'd4, 1'b0});
`endif

        // Asynchronous reset while on word 1.
        @(negedge clk);
        send(6'd5, D2);
        repeat (3) @(negedge clk);
        chk("rstx_word1", {61'd0, cyc, adr}, {61'd0, 1'b1, 2'd1});
        #1 rst = 1'b1;
        #1;
        chk("rstx_async", {cyc, cmd_ready, adr, stb}, {1'b0, 1'b1, 2'd0, 48'd0});
        @(negedge clk);
        rst  = 1'b0;
        @(negedge clk);
        base = log_n;
        send(6'd5, D3);
        chk("rstx_restart", {cyc, adr, dat}, {1'b1, 2'd0, 32'h2001});
        wait_idle(20);
        chk("rstx_count", 64'(log_n - base), 64'd4);
        chk_log("rstx", base, D3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
